// File: rtl/instr_l1_refill_ctrl.sv
// instr_l1_refill_ctrl: I-L1 miss/refill, flush sequencing and hit/miss statistics
module instr_l1_refill_ctrl #(
  parameter int ADDR_SIZE      = 14,
  parameter int WORD_SIZE      = 32,
  parameter int WORDS_PER_LINE = 8,
  parameter int CNT_BITS       = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_req,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  output logic                 cpu_ready,
  output logic [WORD_SIZE-1:0] cpu_instr,
  input  logic                 flush,
  output logic                 cache_reset,
  output logic                 cache_we,
  output logic [ADDR_SIZE-1:0] cache_addr,
  output logic [WORD_SIZE-1:0] cache_data,
  input  logic                 cache_hit,
  input  logic [WORD_SIZE-1:0] cache_dout,
  output logic                 mem_req,
  output logic [ADDR_SIZE-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic                 mem_rvalid,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 stats_clr,
  output logic [CNT_BITS-1:0]  hit_cnt,
  output logic [CNT_BITS-1:0]  miss_cnt
);
  localparam int OFF_BITS = $clog2(WORDS_PER_LINE);

  typedef enum logic [2:0] {IDLE, REQ, FILL, DONE, FLUSH} state_t;

  state_t                r_state;
  logic [ADDR_SIZE-1:0]  r_line;
  logic [OFF_BITS-1:0]   r_beat;
  logic                  r_pend;
  logic                  r_mem_req;
  logic                  r_cache_reset;
  logic [CNT_BITS-1:0]   r_hit_cnt;
  logic [CNT_BITS-1:0]   r_miss_cnt;
  logic                  w_idle;
  logic                  w_fill;
  logic                  w_miss;
  logic                  w_last;

  assign w_idle = r_state == IDLE;
  assign w_fill = r_state == FILL;
  assign w_miss = w_idle & ~flush & cpu_req & ~cache_hit;
  assign w_last = r_beat == OFF_BITS'(WORDS_PER_LINE - 1);

  assign cpu_ready   = w_idle & cpu_req & cache_hit & ~flush;
  assign cpu_instr   = w_idle ? cache_dout : '0;
  assign cache_addr  = w_idle ? cpu_addr : w_fill ? (r_line | ADDR_SIZE'(r_beat)) : '0;
  assign cache_we    = w_fill & mem_rvalid;
  assign cache_data  = w_fill ? mem_rdata : '0;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_req ? r_line : '0;
  assign cache_reset = r_cache_reset;
  assign hit_cnt     = r_hit_cnt;
  assign miss_cnt    = r_miss_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_line        <= '0;
      r_beat        <= '0;
      r_pend        <= 1'b0;
      r_mem_req     <= 1'b0;
      r_cache_reset <= 1'b0;
    end else begin
      // a flush seen mid-refill is parked until the line is complete
      r_pend <= (r_state != FLUSH) & (r_pend | (flush & ~w_idle));
      case (r_state)
        IDLE: begin
          if (flush) begin
            r_state       <= FLUSH;
            r_cache_reset <= 1'b1;
          end else if (w_miss) begin
            r_state   <= REQ;
            r_line    <= {cpu_addr[ADDR_SIZE-1:OFF_BITS], {OFF_BITS{1'b0}}};
            r_beat    <= '0;
            r_mem_req <= 1'b1;
          end
        end
        REQ: begin
          if (mem_ack) begin
            r_state   <= FILL;
            r_mem_req <= 1'b0;
          end
        end
        FILL: begin
          if (mem_rvalid) begin
            r_beat <= r_beat + OFF_BITS'(1);
            if (w_last) r_state <= DONE;
          end
        end
        DONE: begin
          if (r_pend | flush) begin
            r_state       <= FLUSH;
            r_cache_reset <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        FLUSH: begin
          r_state       <= IDLE;
          r_cache_reset <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (stats_clr) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (cpu_ready & ~&r_hit_cnt) r_hit_cnt <= r_hit_cnt + CNT_BITS'(1);
      if (w_miss & ~&r_miss_cnt) r_miss_cnt <= r_miss_cnt + CNT_BITS'(1);
    end
  end
endmodule

// File: tb/tb_instr_l1_refill_ctrl.sv
// tb_instr_l1_refill_ctrl: vector table, directed miss/flush/reset sequences and randomized fetches vs a line-valid model
module tb_instr_l1_refill_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req;
  logic [13:0] cpu_addr;
  logic        cpu_ready;
  logic [31:0] cpu_instr;
  logic        flush;
  logic        cache_reset;
  logic        cache_we;
  logic [13:0] cache_addr;
  logic [31:0] cache_data;
  logic        cache_hit;
  logic [31:0] cache_dout;
  logic        mem_req;
  logic [13:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stats_clr;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  logic        frc;
  logic        frc_hit;
  logic [31:0] frc_dout;
  logic [31:0] arr [0:16383];
  bit          vld [0:2047];

  int n_chk = 0;
  int n_pass = 0;

  instr_l1_refill_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_instr(cpu_instr), .flush(flush),
    .cache_reset(cache_reset), .cache_we(cache_we), .cache_addr(cache_addr),
    .cache_data(cache_data), .cache_hit(cache_hit), .cache_dout(cache_dout),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .stats_clr(stats_clr),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // array stand-in: unbounded capacity, a line turns valid when offset 7 lands
  assign cache_hit  = frc ? frc_hit  : vld[cache_addr[13:3]];
  assign cache_dout = frc ? frc_dout : arr[cache_addr];

  always @(negedge clk) begin
    if (cache_reset) begin
      for (int i = 0; i < 2048; i++) vld[i] <= 1'b0;
    end else if (cache_we) begin
      arr[cache_addr] <= cache_data;
      if (cache_addr[2:0] == 3'd7) vld[cache_addr[13:3]] <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int gcount(input logic [15:0] g);
    int b = 0;
    int n = 0;
    int i = 0;
    while (b < 8) begin
      if (i < 16 && g[i]) n++;
      else b++;
      i++;
    end
    return n;
  endfunction

  function automatic logic [31:0] dfn(input logic [10:0] ln);
    return 32'hD000_0000 | (32'(ln) << 4);
  endfunction

  task automatic do_hit(input logic [13:0] a, input logic [31:0] exp);
    cpu_req = 1'b1;
    cpu_addr = a;
    #2;
    chk("hit_ready", 32'(cpu_ready), 1);
    chk("hit_instr", cpu_instr, exp);
    cyc();
  endtask

  // Drives a miss from its IDLE cycle (c=0) and plays the memory side.
  task automatic fetch_miss(input logic [13:0] addr, input int dly, input logic [15:0] gaps,
                            input logic [31:0] dbase, input int fl_b, input int drop_b,
                            input int ab_b, input int budget, input bit junk,
                            output int rdy, output int nwe, output int rc, output int nr);
    logic [13:0] base;
    int beats, gi, reqc;
    bit acked, fl_done, v;
    base = {addr[13:3], 3'b000};
    beats = 0; gi = 0; reqc = 0; acked = 0; fl_done = 0;
    rdy = -1; nwe = 0; rc = -1; nr = 0;
    cpu_req = 1'b1;
    cpu_addr = addr;
    for (int c = 0; c < budget; c++) begin
      mem_ack = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = $urandom;
      flush = 1'b0;
      v = 0;
      if (acked) begin
        if (beats < 8) begin
          v = !(gi < 16 && gaps[gi]);
          gi++;
        end
        if (v) mem_rdata = dbase + 32'(beats);
        mem_rvalid = v;
        if (beats == fl_b && !fl_done) begin
          flush = 1'b1;
          fl_done = 1;
        end
        if (beats == drop_b) begin
          cpu_req = 1'b0;
          cpu_addr = addr ^ 14'h0808;
        end
        if (v && beats == ab_b) begin
          reset_n = 1'b0;
          #2;
          chk("abort_mem_req", 32'(mem_req), 0);
          chk("abort_cache_we", 32'(cache_we), 0);
          mem_rvalid = 1'b0;
          return;
        end
      end else begin
        if (mem_req) begin
          mem_ack = (reqc == dly);
          reqc++;
        end
        mem_rvalid = junk ? 1'($urandom) : 1'b0;
      end
      #2;
      if (c == 0) chk("miss_no_ready", 32'(cpu_ready), 0);
      if (mem_req) chk("mem_addr", 32'(mem_addr), 32'(base));
      if (acked) chk("mem_req_drop", 32'(mem_req), 0);
      if (cache_we) begin
        chk("fill_addr", 32'(cache_addr), 32'(base) + 32'(nwe));
        chk("fill_data", cache_data, dbase + 32'(nwe));
        nwe++;
      end
      if (cache_reset) begin
        if (nr == 0) rc = c;
        nr++;
      end
      if (cpu_ready) begin
        rdy = c;
        chk("replay_instr", cpu_instr, dbase + 32'(addr[2:0]));
      end
      if (mem_ack) acked = 1;
      if (v) beats++;
      cyc();
      if (rdy >= 0) break;
    end
    mem_ack = 1'b0;
    mem_rvalid = 1'b0;
    flush = 1'b0;
  endtask

  typedef struct {
    logic        req;
    logic [13:0] addr;
    logic        fl;
    logic        hit;
    logic [31:0] dout;
    logic        rdy;
    logic [31:0] instr;
    logic        nxt_mreq;
    logic        nxt_crst;
  } vec_t;

  vec_t tbl [7];
  logic [10:0] pool [6];
  bit mdl_v [6];

  initial begin
    int rdy, nwe, rc, nr, exp_h, exp_m, dly, op, p;
    logic [15:0] g;
    logic [2:0] off;
    logic [13:0] a;

    tbl[0] = '{1'b1, 14'h0100, 1'b0, 1'b1, 32'h1111_0000, 1'b1, 32'h1111_0000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 14'h0101, 1'b0, 1'b1, 32'h2222_0000, 1'b0, 32'h2222_0000, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 14'h1235, 1'b0, 1'b0, 32'h3333_0000, 1'b0, 32'h3333_0000, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 14'h0040, 1'b1, 1'b1, 32'h4444_0000, 1'b0, 32'h4444_0000, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 14'h3FFF, 1'b0, 1'b0, 32'h5555_0000, 1'b0, 32'h5555_0000, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 14'h3FFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 14'h0200, 1'b1, 1'b0, 32'h7777_0000, 1'b0, 32'h7777_0000, 1'b0, 1'b1};
    pool = '{11'h008, 11'h009, 11'h246, 11'h7FF, 11'h000, 11'h100};

    reset_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0; mem_ack = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0; stats_clr = 1'b0;
    frc = 1'b0; frc_hit = 1'b0; frc_dout = '0;
    repeat (2) cyc();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_cache_we", 32'(cache_we), 0);
    chk("rst_cache_reset", 32'(cache_reset), 0);
    chk("rst_hit_cnt", 32'(hit_cnt), 0);
    chk("rst_miss_cnt", 32'(miss_cnt), 0);
    reset_n = 1'b1;

    // idle-path vectors, each followed by a reset back to IDLE
    frc = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cpu_req = tbl[i].req; cpu_addr = tbl[i].addr; flush = tbl[i].fl;
      frc_hit = tbl[i].hit; frc_dout = tbl[i].dout;
      #2;
      chk($sformatf("vec%0d_ready", i), 32'(cpu_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_instr", i), cpu_instr, tbl[i].instr);
      chk($sformatf("vec%0d_caddr", i), 32'(cache_addr), 32'(tbl[i].addr));
      chk($sformatf("vec%0d_we", i), 32'(cache_we), 0);
      cyc();
      cpu_req = 1'b0; flush = 1'b0;
      #2;
      chk($sformatf("vec%0d_next_mreq", i), 32'(mem_req), 32'(tbl[i].nxt_mreq));
      chk($sformatf("vec%0d_next_creset", i), 32'(cache_reset), 32'(tbl[i].nxt_crst));
      if (tbl[i].nxt_mreq) chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].addr & 14'h3FF8));
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      cyc();
    end
    frc = 1'b0;

    // first fetch after reset, then a hit in the same line
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    fetch_miss(14'h0040, 0, 16'h0, 32'hA0, -1, -1, -1, 20, 0, rdy, nwe, rc, nr);
    chk("a_ready_cycle", 32'(rdy), 11);
    chk("a_we_count", 32'(nwe), 8);
    chk("a_miss_cnt", 32'(miss_cnt), 1);
    do_hit(14'h0043, 32'hA3);
    chk("a_hit_cnt", 32'(hit_cnt), 2);

    // stalled ack and two rvalid gaps
    fetch_miss(14'h1235, 3, 16'h0024, 32'hB0, -1, -1, -1, 30, 0, rdy, nwe, rc, nr);
    chk("b_ready_cycle", 32'(rdy), 16);
    chk("b_we_count", 32'(nwe), 8);
    chk("b_miss_cnt", 32'(miss_cnt), 2);

    // fetch dropped and redirected mid-fill
    fetch_miss(14'h0204, 0, 16'h0, 32'hC0, -1, 2, -1, 16, 0, rdy, nwe, rc, nr);
    chk("e_no_ready", 32'(rdy), 32'hFFFF_FFFF);
    chk("e_we_count", 32'(nwe), 8);
    do_hit(14'h0204, 32'hC4);

    // hit counter saturation and clear priority
    stats_clr = 1'b1; cpu_req = 1'b0;
    cyc();
    stats_clr = 1'b0;
    chk("f_clr_hit", 32'(hit_cnt), 0);
    chk("f_clr_miss", 32'(miss_cnt), 0);
    cpu_req = 1'b1; cpu_addr = 14'h0203;
    repeat (65534) cyc();
    chk("f_hit_fffe", 32'(hit_cnt), 32'hFFFE);
    cyc();
    chk("f_hit_ffff", 32'(hit_cnt), 32'hFFFF);
    repeat (2) cyc();
    chk("f_hit_hold", 32'(hit_cnt), 32'hFFFF);
    stats_clr = 1'b1;
    #2;
    chk("f_clr_with_hit_ready", 32'(cpu_ready), 1);
    cyc();
    stats_clr = 1'b0; cpu_req = 1'b0;
    chk("f_clr_with_hit", 32'(hit_cnt), 0);

    // flush pulse at fill beat 3
    fetch_miss(14'h0306, 0, 16'h0, 32'hE0, 3, -1, -1, 12, 0, rdy, nwe, rc, nr);
    chk("c_no_ready", 32'(rdy), 32'hFFFF_FFFF);
    chk("c_we_count", 32'(nwe), 8);
    chk("c_creset_count", 32'(nr), 1);
    chk("c_creset_cycle", 32'(rc), 11);
    fetch_miss(14'h0306, 0, 16'h0, 32'hE0, -1, -1, -1, 20, 0, rdy, nwe, rc, nr);
    chk("c_refetch_cycle", 32'(rdy), 11);
    chk("c_refetch_creset", 32'(nr), 0);

    // reset asserted at beat 4, leftover beats must not write
    fetch_miss(14'h0500, 0, 16'h0, 32'hF0, -1, -1, 4, 20, 0, rdy, nwe, rc, nr);
    chk("d_we_before_abort", 32'(nwe), 4);
    cyc();
    reset_n = 1'b1; cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1; mem_rdata = $urandom;
      #2;
      chk("d_leftover_we", 32'(cache_we), 0);
      chk("d_leftover_mreq", 32'(mem_req), 0);
      cyc();
    end
    mem_rvalid = 1'b0;
    chk("d_miss_cnt_cleared", 32'(miss_cnt), 0);
    fetch_miss(14'h0500, 0, 16'h0, 32'hF0, -1, -1, -1, 20, 0, rdy, nwe, rc, nr);
    chk("d_fresh_cycle", 32'(rdy), 11);
    chk("d_fresh_we", 32'(nwe), 8);
    chk("d_fresh_miss_cnt", 32'(miss_cnt), 1);

    // randomized fetch/flush mix against the line-valid model
    flush = 1'b1; cpu_req = 1'b0;
    cyc();
    flush = 1'b0;
    #2;
    chk("r_init_creset", 32'(cache_reset), 1);
    cyc();
    stats_clr = 1'b1;
    cyc();
    stats_clr = 1'b0;
    exp_h = 0; exp_m = 0;
    for (int i = 0; i < 6; i++) mdl_v[i] = 0;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 7);
      p = $urandom_range(0, 5);
      off = 3'($urandom);
      a = {pool[p], off};
      if (op == 0) begin
        flush = 1'b1; cpu_req = 1'($urandom); cpu_addr = a;
        #2;
        chk("r_flush_no_ready", 32'(cpu_ready), 0);
        cyc();
        flush = 1'b0; cpu_req = 1'b0;
        #2;
        chk("r_creset", 32'(cache_reset), 1);
        cyc();
        for (int k = 0; k < 6; k++) mdl_v[k] = 0;
      end else if (op == 1) begin
        cpu_req = 1'b0; mem_rvalid = 1'b1;
        #2;
        chk("r_idle_no_we", 32'(cache_we), 0);
        cyc();
        mem_rvalid = 1'b0;
      end else if (mdl_v[p]) begin
        do_hit(a, dfn(pool[p]) + 32'(off));
        exp_h++;
      end else begin
        dly = $urandom_range(0, 3);
        g = 16'($urandom & $urandom);
        fetch_miss(a, dly, g, dfn(pool[p]), -1, -1, -1, 40, 1'($urandom), rdy, nwe, rc, nr);
        chk("r_ready_cycle", 32'(rdy), 32'(11 + dly + gcount(g)));
        chk("r_we_count", 32'(nwe), 8);
        mdl_v[p] = 1;
        exp_h++;
        exp_m++;
      end
    end
    cpu_req = 1'b0;
    #2;
    chk("r_hit_cnt", 32'(hit_cnt), 32'(exp_h));
    chk("r_miss_cnt", 32'(miss_cnt), 32'(exp_m));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
